aes_axi_sequencer: RTL and testbench

//  Parametrised register-side sequencer for the AES_Comp core. It stages a key and a data block
//  in WORD_W-bit words and runs the key-load / encrypt handshakes. Results go into an OUT_DEPTH

---
 rtl/aes_axi_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_aes_axi_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axi_sequencer.sv
// Register-side sequencer for AES_Comp: stages key/data words, drives the core
// handshakes and queues results in a FIFO with latency, timeout and error tracking.
module aes_axi_sequencer #(
  parameter int WORD_W    = 32,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 1024,
  localparam int NW = 128 / WORD_W,
  localparam int IW = $clog2(NW),
  localparam int PW = $clog2(OUT_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [IW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              key_load,
  input  logic              start,
  input  logic              rd_pop,
  input  logic [IW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [LW-1:0]     fifo_level,
  output logic              busy,
  output logic              key_valid,
  output logic [CNT_W-1:0]  last_cycles,
  output logic              err,
  input  logic              err_clr,
  output logic [127:0]      aes_Kin,
  output logic [127:0]      aes_Din,
  output logic              aes_Krdy,
  output logic              aes_Drdy,
  output logic              aes_EN,
  input  logic [127:0]      aes_Dout,
  input  logic              aes_BSY
);

  typedef enum logic [2:0] {IDLE, KPULSE, KWAIT, DPULSE, DWAIT} state_t;

  state_t           state_q, state_d;
  logic [127:0]     key_stage_q, key_stage_d, data_stage_q, data_stage_d;
  logic [127:0]     kin_q, kin_d, din_q, din_d;
  logic             krdy_q, krdy_d, drdy_q, drdy_d, en_q, en_d;
  logic             key_valid_q, key_valid_d, err_q, err_d;
  logic [CNT_W-1:0] timer_q, timer_d, last_cycles_q, last_cycles_d;
  logic [127:0]     mem_q [OUT_DEPTH];
  logic [127:0]     mem_d [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop, err_set, fifo_full;
  logic [127:0]     head;

  assign fifo_full = (level_q == LW'(OUT_DEPTH));
  assign pop       = rd_pop && (level_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    key_stage_d   = key_stage_q;
    data_stage_d  = data_stage_q;
    kin_d         = kin_q;
    din_d         = din_q;
    krdy_d        = 1'b0;
    drdy_d        = 1'b0;
    en_d          = 1'b1;
    key_valid_d   = key_valid_q;
    timer_d       = timer_q;
    last_cycles_d = last_cycles_q;
    push          = 1'b0;
    err_set       = 1'b0;

    if (wr_en) begin
      if (wr_sel) data_stage_d[int'(wr_idx)*WORD_W +: WORD_W] = wr_data;
      else        key_stage_d[int'(wr_idx)*WORD_W +: WORD_W]  = wr_data;
    end

    if (state_q != IDLE && (key_load || start)) err_set = 1'b1;

    case (state_q)
      IDLE: begin
        if (key_load) begin
          kin_d       = key_stage_q;
          key_valid_d = 1'b0;
          krdy_d      = 1'b1;
          state_d     = KPULSE;
          if (start) err_set = 1'b1;
        end else if (start) begin
          if (key_valid_q && !fifo_full) begin
            din_d   = data_stage_q;
            drdy_d  = 1'b1;
            state_d = DPULSE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      KPULSE: begin
        timer_d = '0;
        state_d = KWAIT;
      end
      DPULSE: begin
        timer_d = '0;
        state_d = DWAIT;
      end
      KWAIT, DWAIT: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        // timer_q is 0 only in the first wait cycle, where BSY may not have risen yet
        if (timer_q != '0 && !aes_BSY) begin
          state_d = IDLE;
          if (state_q == KWAIT) begin
            key_valid_d = 1'b1;
          end else begin
            push          = 1'b1;
            last_cycles_d = timer_q;
          end
        end else if (aes_BSY && timer_q >= CNT_W'(TIMEOUT)) begin
          state_d     = IDLE;
          err_set     = 1'b1;
          key_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = err_clr ? 1'b0 : (err_q | err_set);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = aes_Dout;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      key_stage_q   <= '0;
      data_stage_q  <= '0;
      kin_q         <= '0;
      din_q         <= '0;
      krdy_q        <= 1'b0;
      drdy_q        <= 1'b0;
      en_q          <= 1'b0;
      key_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      timer_q       <= '0;
      last_cycles_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      key_stage_q   <= key_stage_d;
      data_stage_q  <= data_stage_d;
      kin_q         <= kin_d;
      din_q         <= din_d;
      krdy_q        <= krdy_d;
      drdy_q        <= drdy_d;
      en_q          <= en_d;
      key_valid_q   <= key_valid_d;
      err_q         <= err_d;
      timer_q       <= timer_d;
      last_cycles_q <= last_cycles_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data     = (level_q != '0) ? head[int'(rd_idx)*WORD_W +: WORD_W] : '0;
  assign rd_valid    = (level_q != '0);
  assign fifo_level  = level_q;
  assign busy        = (state_q != IDLE);
  assign key_valid   = key_valid_q;
  assign last_cycles = last_cycles_q;
  assign err         = err_q;
  assign aes_Kin     = kin_q;
  assign aes_Din     = din_q;
  assign aes_Krdy    = krdy_q;
  assign aes_Drdy    = drdy_q;
  assign aes_EN      = en_q;

endmodule

// File: tb/tb_aes_axi_sequencer.sv
// Self-checking bench for aes_axi_sequencer: two instances (32- and 64-bit words)
// against simple AES_Comp stand-ins and a queue-based reference model.
module tb_aes_axi_sequencer;

  localparam int TO_A = 1024;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // instance A: WORD_W=32
  logic         wr_en_a = 0, wr_sel_a = 0, key_load_a = 0, start_a = 0, rd_pop_a = 0, err_clr_a = 0;
  logic [1:0]   wr_idx_a = 0, rd_idx_a = 0;
  logic [31:0]  wr_data_a = 0, rd_data_a, last_cycles_a;
  logic         rd_valid_a, busy_a, key_valid_a, err_a, krdy_a, drdy_a, en_a, bsy_a;
  logic [2:0]   fifo_level_a;
  logic [127:0] kin_a, din_a, dout_a;

  // instance B: WORD_W=64
  logic         wr_en_b = 0, wr_sel_b = 0, key_load_b = 0, start_b = 0, rd_pop_b = 0, err_clr_b = 0;
  logic [0:0]   wr_idx_b = 0, rd_idx_b = 0;
  logic [63:0]  wr_data_b = 0, rd_data_b;
  logic [31:0]  last_cycles_b;
  logic         rd_valid_b, busy_b, key_valid_b, err_b, krdy_b, drdy_b, en_b, bsy_b;
  logic [2:0]   fifo_level_b;
  logic [127:0] kin_b, din_b, dout_b;

  aes_axi_sequencer #(.WORD_W(32), .OUT_DEPTH(4), .CNT_W(32), .TIMEOUT(TO_A)) u_dut_a (
    .CLK(CLK), .RSTn(RSTn), .wr_en(wr_en_a), .wr_sel(wr_sel_a), .wr_idx(wr_idx_a),
    .wr_data(wr_data_a), .key_load(key_load_a), .start(start_a), .rd_pop(rd_pop_a),
    .rd_idx(rd_idx_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .fifo_level(fifo_level_a),
    .busy(busy_a), .key_valid(key_valid_a), .last_cycles(last_cycles_a), .err(err_a),
    .err_clr(err_clr_a), .aes_Kin(kin_a), .aes_Din(din_a), .aes_Krdy(krdy_a),
    .aes_Drdy(drdy_a), .aes_EN(en_a), .aes_Dout(dout_a), .aes_BSY(bsy_a));

  aes_axi_sequencer #(.WORD_W(64), .OUT_DEPTH(4), .CNT_W(32), .TIMEOUT(TO_A)) u_dut_b (
    .CLK(CLK), .RSTn(RSTn), .wr_en(wr_en_b), .wr_sel(wr_sel_b), .wr_idx(wr_idx_b),
    .wr_data(wr_data_b), .key_load(key_load_b), .start(start_b), .rd_pop(rd_pop_b),
    .rd_idx(rd_idx_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .fifo_level(fifo_level_b),
    .busy(busy_b), .key_valid(key_valid_b), .last_cycles(last_cycles_b), .err(err_b),
    .err_clr(err_clr_b), .aes_Kin(kin_b), .aes_Din(din_b), .aes_Krdy(krdy_b),
    .aes_Drdy(drdy_b), .aes_EN(en_b), .aes_Dout(dout_b), .aes_BSY(bsy_b));

  // Core stand-in: returns the FIPS-197 ciphertext for the FIPS pair, a keyed mix otherwise
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'hc3a5_0f1e_9b7d_2468_55aa_e1d2_3c4b_8f70;
  endfunction

  // Core stand-ins go busy for blen cycles after each handshake and show garbage while busy
  int           blen_a = 1, blen_b = 1, cnt_a, cnt_b;
  logic         force_bsy_a = 1'b0;
  logic [127:0] res_a, res_b;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_a <= 0; res_a <= '0; cnt_b <= 0; res_b <= '0;
    end else begin
      if (krdy_a || drdy_a) cnt_a <= blen_a;
      else if (cnt_a != 0)  cnt_a <= cnt_a - 1;
      if (drdy_a) res_a <= core_fn(kin_a, din_a);
      if (krdy_b || drdy_b) cnt_b <= blen_b;
      else if (cnt_b != 0)  cnt_b <= cnt_b - 1;
      if (drdy_b) res_b <= core_fn(kin_b, din_b);
    end
  end

  assign bsy_a  = force_bsy_a || (cnt_a != 0);
  assign dout_a = bsy_a ? ~res_a : res_a;
  assign bsy_b  = (cnt_b != 0);
  assign dout_b = bsy_b ? ~res_b : res_b;

  int krdy_n_a = 0, drdy_n_a = 0;
  always @(posedge CLK) begin
    if (krdy_a) krdy_n_a <= krdy_n_a + 1;
    if (drdy_a) drdy_n_a <= drdy_n_a + 1;
  end

  // Reference model state for instance A
  logic [127:0] model_q[$];
  logic [127:0] model_key;
  bit           model_kv, model_err;

  typedef struct {
    bit do_start;
    bit do_pop;
    int blen;
    int exp_level;
    bit exp_err;
  } vec_t;
  vec_t vecs[10];

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_block_a(input bit sel, input logic [127:0] blk);
    for (int i = 0; i < 4; i++) begin
      wr_en_a = 1; wr_sel_a = sel; wr_idx_a = 2'(i); wr_data_a = blk[i*32 +: 32];
      step();
    end
    wr_en_a = 0;
  endtask

  task automatic write_block_b(input bit sel, input logic [127:0] blk);
    for (int i = 0; i < 2; i++) begin
      wr_en_b = 1; wr_sel_b = sel; wr_idx_b = 1'(i); wr_data_b = blk[i*64 +: 64];
      step();
    end
    wr_en_b = 0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 3000) begin step(); n++; end
    checkOutput("idle_reached_a", busy_a, 0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (busy_b && n < 3000) begin step(); n++; end
    checkOutput("idle_reached_b", busy_b, 0);
  endtask

  task automatic read_head_a(output logic [127:0] blk);
    for (int i = 0; i < 4; i++) begin
      rd_idx_a = 2'(i); #1;
      blk[i*32 +: 32] = rd_data_a;
    end
  endtask

  task automatic read_head_b(output logic [127:0] blk);
    for (int i = 0; i < 2; i++) begin
      rd_idx_b = 1'(i); #1;
      blk[i*64 +: 64] = rd_data_b;
    end
  endtask

  task automatic load_key_a(input logic [127:0] k, input int b);
    write_block_a(0, k);
    blen_a = b;
    key_load_a = 1; step(); key_load_a = 0;
    wait_idle_a();
  endtask

  // Runs one start on A and updates the model from the acceptance rules
  task automatic job_and_model_a(input logic [127:0] d, input int b);
    int dn;
    write_block_a(1, d);
    blen_a = b;
    dn = drdy_n_a;
    start_a = 1; step(); start_a = 0;
    wait_idle_a();
    if (model_kv && model_q.size() < 4) begin
      model_q.push_back(core_fn(model_key, d));
      checkOutput("job_drdy_pulses", drdy_n_a - dn, 1);
      checkOutput("job_last_cycles", last_cycles_a, b);
    end else begin
      model_err = 1;
      checkOutput("refused_drdy_pulses", drdy_n_a - dn, 0);
    end
  endtask

  task automatic pop_check_a();
    logic [127:0] h;
    if (model_q.size() > 0) begin
      read_head_a(h);
      checkOutput("fifo_head", h, model_q.pop_front());
    end else begin
      rd_idx_a = 2'($urandom_range(0, 3)); #1;
      checkOutput("empty_rd_data", rd_data_a, 0);
    end
    rd_pop_a = 1; step(); rd_pop_a = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.do_start) job_and_model_a({$urandom, $urandom, $urandom, $urandom}, v.blen);
    if (v.do_pop) pop_check_a();
  endtask

  task automatic check_all_zero_a(input string tag);
    checkOutput({tag, "_rd_valid"}, rd_valid_a, 0);
    checkOutput({tag, "_level"}, fifo_level_a, 0);
    checkOutput({tag, "_busy"}, busy_a, 0);
    checkOutput({tag, "_key_valid"}, key_valid_a, 0);
    checkOutput({tag, "_last_cycles"}, last_cycles_a, 0);
    checkOutput({tag, "_err"}, err_a, 0);
    checkOutput({tag, "_rd_data"}, rd_data_a, 0);
    checkOutput({tag, "_kin"}, kin_a, 0);
    checkOutput({tag, "_din"}, din_a, 0);
    checkOutput({tag, "_krdy_drdy"}, {krdy_a, drdy_a}, 0);
    checkOutput({tag, "_en"}, en_a, 0);
  endtask

  initial begin
    logic [127:0] blk, d2;
    int n, kn, dn, op;

    vecs[0] = '{1, 0, 3, 1, 0};
    vecs[1] = '{1, 0, 1, 2, 0};
    vecs[2] = '{1, 0, 6, 3, 0};
    vecs[3] = '{1, 0, 2, 4, 0};
    vecs[4] = '{1, 0, 2, 4, 1};
    vecs[5] = '{0, 1, 0, 3, 1};
    vecs[6] = '{0, 1, 0, 2, 1};
    vecs[7] = '{0, 1, 0, 1, 1};
    vecs[8] = '{0, 1, 0, 0, 1};
    vecs[9] = '{0, 1, 0, 0, 1};

    $display("[TB] reset state");
    repeat (3) step();
    check_all_zero_a("reset");
    RSTn = 1;
    step();
    checkOutput("en_after_reset", en_a, 1);

    $display("[TB] protocol errors");
    dn = drdy_n_a;
    write_block_a(1, FIPS_PT);
    start_a = 1; step(); start_a = 0;
    repeat (4) step();
    checkOutput("nokey_no_drdy", drdy_n_a - dn, 0);
    checkOutput("nokey_err", err_a, 1);
    err_clr_a = 1; step(); err_clr_a = 0;
    checkOutput("err_cleared", err_a, 0);

    write_block_a(0, FIPS_KEY);
    kn = krdy_n_a; dn = drdy_n_a; blen_a = 3;
    key_load_a = 1; start_a = 1; step(); key_load_a = 0; start_a = 0;
    wait_idle_a();
    checkOutput("both_krdy", krdy_n_a - kn, 1);
    checkOutput("both_drdy", drdy_n_a - dn, 0);
    checkOutput("both_err", err_a, 1);
    checkOutput("both_key_valid", key_valid_a, 1);
    err_clr_a = 1; step(); err_clr_a = 0;

    $display("[TB] FIPS-197 vector, 32-bit words");
    write_block_a(1, FIPS_PT);
    blen_a = 5;
    start_a = 1; step(); start_a = 0;
    n = 1;
    while (!rd_valid_a && n < 100) begin step(); n++; end
    checkOutput("fips_latency", n, 3 + 5);
    read_head_a(blk);
    checkOutput("fips_block", blk, FIPS_CT);
    rd_idx_a = 2'd0; #1;
    checkOutput("fips_word0", rd_data_a, 32'h70b4c55a);
    checkOutput("fips_last_cycles", last_cycles_a, 5);
    rd_pop_a = 1; step(); rd_pop_a = 0;
    checkOutput("fips_popped", rd_valid_a, 0);
    model_key = FIPS_KEY; model_kv = 1; model_err = 0;

    $display("[TB] fill table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("tbl_level", fifo_level_a, vecs[i].exp_level);
      checkOutput("tbl_err", err_a, vecs[i].exp_err);
      checkOutput("tbl_rd_valid", rd_valid_a, vecs[i].exp_level != 0);
    end
    err_clr_a = 1; step(); err_clr_a = 0;
    model_err = 0;

    $display("[TB] randomized jobs");
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 7);
      if (op == 0) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        load_key_a(blk, $urandom_range(1, 4));
        model_key = blk; model_kv = 1;
      end else if (op <= 4) begin
        job_and_model_a({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 6));
      end else if (op <= 6) begin
        pop_check_a();
      end else begin
        err_clr_a = 1; step(); err_clr_a = 0;
        model_err = 0;
      end
      checkOutput("rnd_level", fifo_level_a, model_q.size());
      checkOutput("rnd_err", err_a, model_err);
      checkOutput("rnd_key_valid", key_valid_a, model_kv);
    end
    while (model_q.size() > 0) pop_check_a();
    checkOutput("drained", rd_valid_a, 0);
    err_clr_a = 1; step(); err_clr_a = 0;

    $display("[TB] busy timeout");
    force_bsy_a = 1;
    start_a = 1; step(); start_a = 0;
    n = 0;
    while (busy_a && n < 2000) begin n++; step(); end
    checkOutput("timeout_busy_cycles", n, TO_A + 2);
    checkOutput("timeout_err", err_a, 1);
    checkOutput("timeout_key_valid", key_valid_a, 0);
    checkOutput("timeout_no_push", fifo_level_a, 0);
    repeat (TO_A + 10 - n) step();
    force_bsy_a = 0;
    err_clr_a = 1; step(); err_clr_a = 0;

    $display("[TB] reset during DWAIT");
    load_key_a(FIPS_KEY, 2);
    write_block_a(1, FIPS_PT);
    blen_a = 20;
    start_a = 1; step(); start_a = 0;
    repeat (4) step();
    checkOutput("pre_reset_busy", busy_a, 1);
    RSTn = 0; #1;
    check_all_zero_a("midreset");
    step(); step();
    RSTn = 1;
    step();
    checkOutput("en_after_midreset", en_a, 1);
    repeat (30) step();
    checkOutput("midreset_no_push", fifo_level_a, 0);

    $display("[TB] FIPS-197 vector, 64-bit words");
    write_block_b(0, FIPS_KEY);
    blen_b = 4;
    key_load_b = 1; step(); key_load_b = 0;
    wait_idle_b();
    checkOutput("b_key_valid", key_valid_b, 1);
    write_block_b(1, FIPS_PT);
    blen_b = 6;
    start_b = 1; step(); start_b = 0;
    wait_idle_b();
    checkOutput("b_level", fifo_level_b, 1);
    read_head_b(blk);
    checkOutput("b_fips_block", blk, FIPS_CT);
    checkOutput("b_last_cycles", last_cycles_b, 6);

    d2 = {$urandom, $urandom, $urandom, $urandom};
    write_block_b(1, d2);
    blen_b = 3;
    start_b = 1; step(); start_b = 0;
    repeat (3 + 1) step();
    rd_pop_b = 1; step(); rd_pop_b = 0;
    checkOutput("b_pushpop_level", fifo_level_b, 1);
    checkOutput("b_pushpop_busy", busy_b, 0);
    read_head_b(blk);
    checkOutput("b_pushpop_head", blk, core_fn(FIPS_KEY, d2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
